// File: rtl/clic_gateway.sv
// CLIC per-source interrupt gateway: synchroniser, edge/level trigger handling,
// pending latch with ack/software clear, sticky lost-edge flag and warm-up gating.

module clic_gw_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       src_i,
    input  logic [1:0] trig_i,
    input  logic       sw_we_i,
    input  logic       sw_i,
    input  logic       ack_hit_i,
    input  logic       ovf_clr_i,
    input  logic       ready_i,
    output logic       ip_o,
    output logic       ovf_o
);
    logic       s, prev;
    logic [1:0] trig_q;
    logic       lvl, edge_hit, clr, ip_d, ovf_d;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s = src_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= src_i;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        lvl      = s ^ trig_i[1];
        edge_hit = trig_i[1] ? (~s & prev) : (s & ~prev);
        clr      = ack_hit_i | (sw_we_i & ~sw_i);
        ip_d     = ip_o;
        ovf_d    = ovf_o;
        if (!ready_i) begin
            ip_d  = 1'b0;
            ovf_d = 1'b0;
        end else if (trig_i != trig_q) begin
            // a trigger reconfiguration drops any pending state left over from the old mode
            ip_d = 1'b0;
        end else begin
            if (!trig_i[0])     ip_d = lvl;
            else if (edge_hit)  ip_d = 1'b1;
            else if (ack_hit_i) ip_d = sw_we_i & sw_i;
            else if (sw_we_i)   ip_d = sw_i;
            if (trig_i[0] && edge_hit && ip_o && !clr) ovf_d = 1'b1;
            else if (ovf_clr_i)                        ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev   <= 1'b0;
            trig_q <= 2'b00;
            ip_o   <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            prev   <= s;
            trig_q <= trig_i;
            ip_o   <= ip_d;
            ovf_o  <= ovf_d;
        end
    end
endmodule

module clic_gateway #(
    parameter int N_SOURCE    = 32,
    parameter int SYNC_STAGES = 2,
    localparam int ID_W       = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_SOURCE-1:0]   irq_src_i,
    input  logic [2*N_SOURCE-1:0] trig_i,
    input  logic [N_SOURCE-1:0]   ip_sw_we_i,
    input  logic [N_SOURCE-1:0]   ip_sw_i,
    input  logic                  ack_valid_i,
    input  logic [ID_W-1:0]       ack_id_i,
    input  logic [N_SOURCE-1:0]   ovf_clr_i,
    output logic [N_SOURCE-1:0]   ip_o,
    output logic [N_SOURCE-1:0]   ovf_o,
    output logic                  ready_o
);
    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] READY_CNT = CNT_W'(SYNC_STAGES + 1);

    logic [CNT_W-1:0]    warm_cnt;
    logic [N_SOURCE-1:0] ack_hit;

    // warm-up covers the synchroniser fill plus one cycle for prev to settle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       warm_cnt <= '0;
        else if (!ready_o) warm_cnt <= warm_cnt + 1'b1;
    end
    assign ready_o = (warm_cnt == READY_CNT);

    generate
        for (genvar i = 0; i < N_SOURCE; i++) begin : g_ack
            assign ack_hit[i] = ack_valid_i && (32'(ack_id_i) == 32'(i));
        end
    endgenerate

    clic_gw_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane [N_SOURCE-1:0] (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .src_i     (irq_src_i),
        .trig_i    (trig_i),
        .sw_we_i   (ip_sw_we_i),
        .sw_i      (ip_sw_i),
        .ack_hit_i (ack_hit),
        .ovf_clr_i (ovf_clr_i),
        .ready_i   (ready_o),
        .ip_o      (ip_o),
        .ovf_o     (ovf_o)
    );
endmodule

// File: tb/tb_clic_gateway.sv
// Directed bench for clic_gateway: a SYNC_STAGES=2 build and a bypass build share stimulus.

module tb_clic_gateway;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] src, sw_we, sw, ovf_clr;
    logic [2*N-1:0] trig;
    logic         ack_valid;
    logic [2:0]   ack_id;
    logic [N-1:0] ip, ovf, ip0, ovf0;
    logic         ready, ready0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clic_gateway #(.N_SOURCE(N), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .irq_src_i(src), .trig_i(trig),
        .ip_sw_we_i(sw_we), .ip_sw_i(sw), .ack_valid_i(ack_valid), .ack_id_i(ack_id),
        .ovf_clr_i(ovf_clr), .ip_o(ip), .ovf_o(ovf), .ready_o(ready)
    );

    clic_gateway #(.N_SOURCE(N), .SYNC_STAGES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .irq_src_i(src), .trig_i(trig),
        .ip_sw_we_i(sw_we), .ip_sw_i(sw), .ack_valid_i(ack_valid), .ack_id_i(ack_id),
        .ovf_clr_i(ovf_clr), .ip_o(ip0), .ovf_o(ovf0), .ready_o(ready0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int idx);
        src[idx] = 1'b1;
        tick();
        src[idx] = 1'b0;
    endtask

    task automatic ack(input logic [2:0] id);
        ack_valid = 1'b1;
        ack_id    = id;
        tick();
        ack_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        src = 5'b01100;
        trig = {2'b00, 2'b10, 2'b11, 2'b01, 2'b01};
        sw_we = '0; sw = '0; ovf_clr = '0; ack_valid = 1'b0; ack_id = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ip", ip, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ready", ready, 0);
        chk("rst_ready0", ready0, 0);
        rst_n = 1'b1;

        // 1: warm-up hides neg-level pending; 3-cycle latency
        tick(); chk("wu1_ip3", ip[3], 0); chk("wu1_ready", ready, 0); chk("wu1_ready0", ready0, 1);
        tick(); chk("wu2_ip3", ip[3], 0); chk("wu2_ready", ready, 0);
        tick(); chk("wu3_ready", ready, 1); chk("wu3_ip", ip, 0);
        tick(); chk("post_wu_ip", ip, 0);
        src[3] = 1'b0;
        #1 chk("byp_ip3_pre", ip0[3], 0);
        tick(); chk("byp_ip3_lat1", ip0[3], 1); chk("lvl_ip3_lat1", ip[3], 0);
        tick(); chk("lvl_ip3_lat2", ip[3], 0);
        tick(); chk("lvl_ip3_lat3", ip[3], 1);

        // 2: pos-edge pulse, ack, overflow, overflow clear
        pulse(0); tick(); chk("edge0_lat2", ip[0], 0);
        tick(); chk("edge0_lat3", ip[0], 1);
        tick(); chk("edge0_hold", ip[0], 1);
        ack(3'd0); chk("ack0", ip[0], 0);
        pulse(0); tick(); tick(); chk("edge0_again", ip[0], 1);
        pulse(0); tick(); chk("ovf0_pre", ovf[0], 0);
        tick(); chk("ovf0_set", ovf[0], 1); chk("ovf0_ip", ip[0], 1);
        ovf_clr[0] = 1'b1; tick(); ovf_clr[0] = 1'b0;
        chk("ovf0_clr", ovf[0], 0);
        ack(3'd0); chk("ack0_b", ip[0], 0);

        // 3: edge coincident with ack keeps pending, no overflow
        pulse(1); tick(); tick(); chk("edge1_set", ip[1], 1);
        pulse(1); tick();
        ack(3'd1); chk("edge_ack_ip1", ip[1], 1); chk("edge_ack_ovf1", ovf[1], 0);
        tick(); chk("edge_ack_hold", ip[1], 1);
        ack(3'd1); chk("ack1", ip[1], 0);

        // 4: neg-edge, sw writes
        src[2] = 1'b0; tick(); tick(); chk("fall2_lat2", ip[2], 0);
        tick(); chk("fall2_set", ip[2], 1);
        sw_we[2] = 1'b1; sw[2] = 1'b0; tick(); sw_we[2] = 1'b0;
        chk("sw0_ip2", ip[2], 0);
        src[2] = 1'b1; tick(); tick(); tick(); chk("rise2_ignored", ip[2], 0);
        sw_we[2] = 1'b1; sw[2] = 1'b1; tick(); sw_we[2] = 1'b0; sw[2] = 1'b0;
        chk("sw1_ip2", ip[2], 1);
        sw_we[2] = 1'b1; tick(); sw_we[2] = 1'b0;
        chk("sw0b_ip2", ip[2], 0);

        // 5: level ignores ack/sw; trig change clears; out-of-range ack ignored
        src[4] = 1'b1; tick(); tick(); tick(); chk("lvl4_set", ip[4], 1);
        sw_we[4] = 1'b1; sw[4] = 1'b0;
        ack(3'd4); sw_we[4] = 1'b0;
        chk("lvl4_ack_sw", ip[4], 1);
        trig[9:8] = 2'b01; tick(); chk("trig4_clr", ip[4], 0);
        tick(); chk("trig4_hold", ip[4], 0);
        pulse(0); tick(); tick(); chk("edge0_c", ip[0], 1);
        ack(3'd7); chk("ack7_ip", ip, 5'b01001); chk("ack7_ovf", ovf, 0);

        // 6: async reset mid-pending, warm-up re-runs
        pulse(0); tick(); tick(); chk("ovf0_b", ovf[0], 1);
        rst_n = 1'b0;
        #2;
        chk("arst_ip", ip, 0); chk("arst_ovf", ovf, 0); chk("arst_ready", ready, 0);
        rst_n = 1'b1;
        tick(); chk("rwu1_ip", ip, 0); chk("rwu1_ip0", ip0, 0);
        tick(); chk("rwu2_ready", ready, 0); chk("rwu2_ip0", ip0, 5'b01000);
        tick(); chk("rwu3_ready", ready, 1); chk("rwu3_ip", ip, 0);
        tick(); chk("rwu4_ip", ip, 5'b01000); chk("rwu4_ovf", ovf, 0);
        src[1] = 1'b1;
        tick(); chk("byp_edge1", ip0[1], 1); chk("sync_edge1_lat1", ip[1], 0);
        tick(); chk("sync_edge1_lat2", ip[1], 0);
        tick(); chk("sync_edge1_lat3", ip[1], 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
